// File: rtl/sort_ram_arbiter.sv
// Round-robin arbiter sharing the single-port 16x8 sort RAM between the sort engine (0) and host port (1).
// Supports bus lock, burst-limited preemption of unlocked owners and a lock-hold watchdog.
module sort_ram_arbiter #(
  parameter int unsigned AW        = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned MAX_HOLD  = 255
) (
  input  logic          C,
  input  logic          anR,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          LOCK0,
  input  logic          LOCK1,
  input  logic          WR0,
  input  logic          WR1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] DATA0,
  input  logic [DW-1:0] DATA1,
  output logic          GNT0Q,
  output logic          GNT1Q,
  output logic          ACK0Q,
  output logic          ACK1Q,
  output logic [DW-1:0] RDATA,
  output logic [AW-1:0] RAM_ADDR,
  output logic [DW-1:0] RAM_DATA,
  output logic          RAM_WREN,
  input  logic [DW-1:0] RAM_Q,
  output logic          TOUTQ
);

  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] burst_cnt, burst_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          sel, own_req, own_lock, own_wr, oth_req;
  logic          issue, rel, rel_tout, tout_nxt;

  assign RDATA = RAM_Q;

  // Owner mux, grant decision, counters and release conditions
  always_comb begin
    sel       = (state == OWN1);
    own_req   = sel ? REQ1 : REQ0;
    own_lock  = sel ? LOCK1 : LOCK0;
    own_wr    = sel ? WR1 : WR0;
    oth_req   = sel ? REQ0 : REQ1;
    RAM_ADDR  = sel ? ADDR1 : ADDR0;
    RAM_DATA  = sel ? DATA1 : DATA0;
    issue     = 1'b0;
    rel       = 1'b0;
    rel_tout  = 1'b0;
    tout_nxt  = 1'b0;
    state_nxt = state;
    last_nxt  = last;
    burst_nxt = burst_cnt;
    hold_nxt  = hold_cnt;

    unique case (state)
      IDLE: begin
        if (REQ0 && (!REQ1 || last)) state_nxt = OWN0;
        else if (REQ1)               state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        issue = own_req;
        if (!oth_req)                                     burst_nxt = '0;
        else if (issue && burst_cnt != CW'(MAX_BURST))    burst_nxt = burst_cnt + CW'(1);
        if (issue)                                        hold_nxt = '0;
        else if (own_lock && hold_cnt != CW'(MAX_HOLD))   hold_nxt = hold_cnt + CW'(1);

        rel_tout = !own_req && own_lock && (hold_nxt == CW'(MAX_HOLD));
        rel      = (!own_req && !own_lock)
                 || (!own_lock && oth_req && (burst_nxt == CW'(MAX_BURST)))
                 || rel_tout;
        if (rel) begin
          last_nxt  = sel;
          burst_nxt = '0;
          hold_nxt  = '0;
          tout_nxt  = rel_tout;
          if (oth_req) state_nxt = sel ? OWN0 : OWN1;
          else         state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    RAM_WREN = issue && own_wr;
  end

  // State, grant, acknowledge and watchdog registers
  always_ff @(posedge C or negedge anR) begin
    if (!anR) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
      hold_cnt  <= '0;
      GNT0Q     <= 1'b0;
      GNT1Q     <= 1'b0;
      ACK0Q     <= 1'b0;
      ACK1Q     <= 1'b0;
      TOUTQ     <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
      hold_cnt  <= hold_nxt;
      GNT0Q     <= (state_nxt == OWN0);
      GNT1Q     <= (state_nxt == OWN1);
      ACK0Q     <= issue && !sel;
      ACK1Q     <= issue && sel;
      TOUTQ     <= tout_nxt;
    end
  end

endmodule

// File: tb/tb_sort_ram_arbiter.sv
// Directed bench for sort_ram_arbiter with a behavioural 16x8 sync RAM and a per-port ACK scoreboard.
module tb_sort_ram_arbiter;

  logic       C = 1'b0;
  logic       anR = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, LOCK0 = 1'b0, LOCK1 = 1'b0, WR0 = 1'b0, WR1 = 1'b0;
  logic [3:0] ADDR0 = '0, ADDR1 = '0;
  logic [7:0] DATA0 = '0, DATA1 = '0;
  logic       GNT0Q, GNT1Q, ACK0Q, ACK1Q, RAM_WREN, TOUTQ;
  logic [7:0] RDATA, RAM_DATA, RAM_Q;
  logic [3:0] RAM_ADDR;

  typedef struct {
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] mem[16];
  logic [7:0] exp_mem[16];
  int         n_assert = 0;
  int         n_fail = 0;

  sort_ram_arbiter dut (
    .C(C), .anR(anR), .REQ0(REQ0), .REQ1(REQ1), .LOCK0(LOCK0), .LOCK1(LOCK1),
    .WR0(WR0), .WR1(WR1), .ADDR0(ADDR0), .ADDR1(ADDR1), .DATA0(DATA0), .DATA1(DATA1),
    .GNT0Q(GNT0Q), .GNT1Q(GNT1Q), .ACK0Q(ACK0Q), .ACK1Q(ACK1Q), .RDATA(RDATA),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WREN(RAM_WREN), .RAM_Q(RAM_Q),
    .TOUTQ(TOUTQ)
  );

  always #5 C = ~C;

  always @(posedge C) begin
    if (RAM_WREN) mem[RAM_ADDR] <= RAM_DATA;
    RAM_Q <= mem[RAM_ADDR];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit p, input bit wr, input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.rd = !wr;
    e.data = wr ? d : exp_mem[a];
    if (wr) exp_mem[a] = d;
    if (p) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  function automatic logic gnt(input bit p);
    return p ? GNT1Q : GNT0Q;
  endfunction

  // Scoreboard monitor: every ACK must match the oldest expected access of that port
  always @(negedge C) begin
    exp_t e;
    if (ACK0Q) begin
      n_assert++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL ack0_unexpected: got ack, expected none at %0t", $time);
      end else begin
        e = q0.pop_front();
        if (e.rd && RDATA !== e.data) begin
          n_fail++;
          $display("FAIL rdata0: got %0h, expected %0h at %0t", RDATA, e.data, $time);
        end
      end
    end
    if (ACK1Q) begin
      n_assert++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL ack1_unexpected: got ack, expected none at %0t", $time);
      end else begin
        e = q1.pop_front();
        if (e.rd && RDATA !== e.data) begin
          n_fail++;
          $display("FAIL rdata1: got %0h, expected %0h at %0t", RDATA, e.data, $time);
        end
      end
    end
  end

  // One access: raise request, wait for grant, check ACK the cycle after issue
  task automatic do_access(input bit p, input bit wr, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    if (p) begin REQ1 = 1'b1; WR1 = wr; ADDR1 = a; DATA1 = d; end
    else   begin REQ0 = 1'b1; WR0 = wr; ADDR0 = a; DATA0 = d; end
    #1;
    while (gnt(p) !== 1'b1 && n < 500) begin
      @(negedge C); #1;
      n++;
    end
    if (n >= 500) chk("grant_timeout", 32'(gnt(p)), 32'd1);
    push(p, wr, a, d);
    @(negedge C); #1;
    chk(p ? "ack1_latency" : "ack0_latency", 32'(p ? ACK1Q : ACK0Q), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge C); anR = 1'b0;
    @(negedge C); anR = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end

    // Reset state
    repeat (2) @(negedge C);
    #1;
    chk("rst_gnt0", 32'(GNT0Q), 32'd0);
    chk("rst_gnt1", 32'(GNT1Q), 32'd0);
    chk("rst_ack", 32'({ACK0Q, ACK1Q}), 32'd0);
    chk("rst_tout", 32'(TOUTQ), 32'd0);
    chk("rst_wren", 32'(RAM_WREN), 32'd0);
    @(negedge C); anR = 1'b1;

    // Test 1: host write A5 to addr 3
    @(negedge C); REQ1 = 1'b1; WR1 = 1'b1; ADDR1 = 4'd3; DATA1 = 8'hA5;
    @(negedge C); #1;
    chk("t1_gnt1", 32'(GNT1Q), 32'd1);
    chk("t1_gnt0", 32'(GNT0Q), 32'd0);
    chk("t1_wren", 32'(RAM_WREN), 32'd1);
    chk("t1_addr", 32'(RAM_ADDR), 32'd3);
    chk("t1_data", 32'(RAM_DATA), 32'hA5);
    push(1'b1, 1'b1, 4'd3, 8'hA5);
    @(negedge C); REQ1 = 1'b0; #1;
    chk("t1_ack1", 32'(ACK1Q), 32'd1);

    // Test 2: host writes 5A to addr 7, engine reads it back
    do_access(1'b1, 1'b1, 4'd7, 8'h5A);
    REQ1 = 1'b0;
    do_access(1'b0, 1'b0, 4'd7, 8'h00);
    REQ0 = 1'b0;
    repeat (2) @(negedge C);

    // Test 3: simultaneous requests after reset, burst limit hands over without a gap
    do_reset();
    @(negedge C);
    REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd3;
    REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 4'd8; DATA0 = 8'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge C);
      if (i > 0) begin ADDR0 = 4'(8 + i); DATA0 = 8'(8'h10 + i); end
      #1;
      chk("t3_gnt0_burst", 32'({GNT0Q, GNT1Q}), 32'b10);
      push(1'b0, 1'b1, 4'(8 + i), 8'(8'h10 + i));
    end
    @(negedge C); REQ0 = 1'b0; #1;
    chk("t3_handover", 32'({GNT0Q, GNT1Q}), 32'b01);
    push(1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge C); REQ1 = 1'b0;
    repeat (2) @(negedge C);

    // Test 4: locked idle owner 0 is forced off after 255 idle cycles
    LOCK0 = 1'b1;
    do_access(1'b0, 1'b0, 4'd7, 8'h00);
    REQ0 = 1'b0; REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd3;
    cnt = 0;
    while (GNT0Q === 1'b1 && cnt < 400) begin
      cnt++;
      @(negedge C); #1;
    end
    chk("t4_hold_cycles", 32'(cnt), 32'd255);
    chk("t4_tout", 32'(TOUTQ), 32'd1);
    chk("t4_gnt1", 32'({GNT0Q, GNT1Q}), 32'b01);
    push(1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge C); REQ1 = 1'b0; LOCK0 = 1'b0; #1;
    chk("t4_tout_pulse", 32'(TOUTQ), 32'd0);
    repeat (2) @(negedge C);

    // Test 5: locked streaming owner 1 is not preempted; releases after unlock
    REQ1 = 1'b1; LOCK1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd3;
    for (int i = 0; i < 13; i++) begin
      @(negedge C);
      if (i == 0) begin REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 4'd1; DATA0 = 8'hC3; end
      if (i > 0) ADDR1 = (i % 2 == 1) ? 4'd7 : 4'd3;
      if (i == 12) LOCK1 = 1'b0;
      #1;
      chk("t5_locked_gnt1", 32'({GNT0Q, GNT1Q}), 32'b01);
      push(1'b1, 1'b0, ADDR1, 8'h00);
    end
    @(negedge C); REQ1 = 1'b0; #1;
    chk("t5_gnt0_after_unlock", 32'({GNT0Q, GNT1Q}), 32'b10);
    push(1'b0, 1'b1, 4'd1, 8'hC3);
    @(negedge C); REQ0 = 1'b0;
    repeat (2) @(negedge C);

    // Test 6: reset mid-burst, then tie goes to requester 0
    REQ0 = 1'b1; WR0 = 1'b1; ADDR0 = 4'd0; DATA0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      if (i > 0) DATA0 = 8'(i);
      #1;
      chk("t6_gnt0", 32'(GNT0Q), 32'd1);
      push(1'b0, 1'b1, 4'd0, 8'(i));
    end
    @(negedge C); DATA0 = 8'hFF; REQ1 = 1'b1; WR1 = 1'b0; ADDR1 = 4'd3;
    #2 anR = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'({GNT0Q, GNT1Q}), 32'b00);
    chk("t6_rst_ack", 32'({ACK0Q, ACK1Q}), 32'b00);
    chk("t6_rst_wren", 32'(RAM_WREN), 32'd0);
    @(negedge C); WR0 = 1'b0; ADDR0 = 4'd7; anR = 1'b1;
    @(negedge C); #1;
    chk("t6_tie_gnt0", 32'({GNT0Q, GNT1Q}), 32'b10);
    push(1'b0, 1'b0, 4'd7, 8'h00);
    @(negedge C); REQ0 = 1'b0;
    @(negedge C); #1;
    chk("t6_then_gnt1", 32'({GNT0Q, GNT1Q}), 32'b01);
    push(1'b1, 1'b0, 4'd3, 8'h00);
    @(negedge C); REQ1 = 1'b0;
    repeat (3) @(negedge C);
    #1;
    chk("sb_q0_drained", 32'(q0.size()), 32'd0);
    chk("sb_q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
